// File: rtl/tdc_pkt_buffer.sv
// Receive-side TDC packet buffer: tags raw packets with channel/error, filters bad parity,
// and queues them in a show-ahead FIFO with saturating monitor counters.
module tdc_pkt_buffer #(
    parameter logic [4:0]  CH_ID      = 5'd0,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter bit          DROP_BAD   = 1'b1
) (
    input  logic        RX_FRAMECLK_I,
    input  logic        user_rst,
    input  logic        en,
    input  logic        pkt_valid,
    input  logic [33:0] tdc_pkt_raw,
    input  logic        parity_chk,
    output logic [37:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic [31:0] pkt_cnt,
    output logic [15:0] parity_err_cnt,
    output logic [15:0] overflow_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned OW    = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [4:0]  ch;
        logic        err;
        logic [31:0] data;
    } word_t;

    word_t           s1_word;
    logic            s1_valid;
    word_t           mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_ptr_inc;
    logic [OW-1:0]   occ;
    logic [OW-1:0]   occ_nxt;
    logic            wr_c;
    logic            pop_c;
    logic            ovf_c;
    word_t           dout_nxt;
    logic            unused_raw_c;

    // Two LSBs of the raw packet are frame-decoder status, not data.
    assign unused_raw_c = ^tdc_pkt_raw[1:0];

    // Stage 1: capture register and input-side counters.
    always_ff @(posedge RX_FRAMECLK_I) begin
        if (user_rst) begin
            s1_valid       <= 1'b0;
            s1_word        <= '0;
            pkt_cnt        <= '0;
            parity_err_cnt <= '0;
        end else begin
            s1_valid <= en && pkt_valid;
            if (en && pkt_valid) begin
                s1_word.ch   <= CH_ID;
                s1_word.err  <= parity_chk;
                s1_word.data <= tdc_pkt_raw[33:2];
                pkt_cnt      <= pkt_cnt + 32'd1;
                if (parity_chk && (parity_err_cnt != 16'hFFFF)) begin
                    parity_err_cnt <= parity_err_cnt + 16'd1;
                end
            end
        end
    end

    // Stage 2 write decision, pop, occupancy and next head-of-FIFO word.
    always_comb begin
        wr_c       = 1'b0;
        ovf_c      = 1'b0;
        pop_c      = dout_valid && dout_ready;
        rd_ptr_inc = rd_ptr + PW'(1);
        occ_nxt    = occ;
        dout_nxt   = word_t'(dout);

        if (s1_valid && !(s1_word.err && DROP_BAD)) begin
            if (fifo_full) begin
                ovf_c = 1'b1;
            end else begin
                wr_c = 1'b1;
            end
        end

        case ({wr_c, pop_c})
            2'b10:   occ_nxt = occ + OW'(1);
            2'b01:   occ_nxt = occ - OW'(1);
            default: occ_nxt = occ;
        endcase

        // Show-ahead: the word behind the head may be the one being written this edge.
        if (pop_c) begin
            if (occ > OW'(1)) begin
                dout_nxt = mem[rd_ptr_inc];
            end else if (wr_c) begin
                dout_nxt = s1_word;
            end
        end else if (wr_c && (occ == '0)) begin
            dout_nxt = s1_word;
        end
    end

    always_ff @(posedge RX_FRAMECLK_I) begin
        if (wr_c) begin
            mem[wr_ptr] <= s1_word;
        end
    end

    // FIFO control, registered status flags and overflow counter.
    always_ff @(posedge RX_FRAMECLK_I) begin
        if (user_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            fifo_empty   <= 1'b1;
            fifo_full    <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr_inc;
            end
            occ        <= occ_nxt;
            dout       <= dout_nxt;
            dout_valid <= (occ_nxt != '0);
            fifo_empty <= (occ_nxt == '0);
            fifo_full  <= (occ_nxt == OW'(DEPTH));
            if (ovf_c && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_pkt_buffer.sv
// Scoreboard bench for tdc_pkt_buffer: one instance drops bad-parity words, one keeps them.
module tb_tdc_pkt_buffer;

    logic        clk = 1'b0;
    logic        user_rst;
    logic        en;
    logic        pkt_valid;
    logic [33:0] raw;
    logic        par;
    logic        dout_ready;
    logic        b_mask;

    logic [37:0] a_dout, b_dout;
    logic        a_dout_valid, b_dout_valid;
    logic        a_fifo_empty, b_fifo_empty;
    logic        a_fifo_full, b_fifo_full;
    logic [31:0] a_pkt_cnt, b_pkt_cnt;
    logic [15:0] a_perr, b_perr;
    logic [15:0] a_ovf, b_ovf;

    logic [37:0] qa[$];
    logic [37:0] qb[$];
    logic [37:0] ea, eb;
    logic [31:0] d;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    tdc_pkt_buffer #(.CH_ID(5'd3), .DEPTH_LOG2(4), .DROP_BAD(1'b1)) u_a (
        .RX_FRAMECLK_I(clk), .user_rst(user_rst), .en(en), .pkt_valid(pkt_valid),
        .tdc_pkt_raw(raw), .parity_chk(par), .dout(a_dout), .dout_valid(a_dout_valid),
        .dout_ready(dout_ready), .fifo_empty(a_fifo_empty), .fifo_full(a_fifo_full),
        .pkt_cnt(a_pkt_cnt), .parity_err_cnt(a_perr), .overflow_cnt(a_ovf)
    );

    tdc_pkt_buffer #(.CH_ID(5'd3), .DEPTH_LOG2(4), .DROP_BAD(1'b0)) u_b (
        .RX_FRAMECLK_I(clk), .user_rst(user_rst), .en(en), .pkt_valid(pkt_valid & ~b_mask),
        .tdc_pkt_raw(raw), .parity_chk(par), .dout(b_dout), .dout_valid(b_dout_valid),
        .dout_ready(dout_ready), .fifo_empty(b_fifo_empty), .fifo_full(b_fifo_full),
        .pkt_cnt(b_pkt_cnt), .parity_err_cnt(b_perr), .overflow_cnt(b_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitors: every accepted output word is compared against the head of its queue.
    always @(negedge clk) begin
        if (!user_rst && a_dout_valid && dout_ready) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_word: got %0h expected none", a_dout);
            end else begin
                ea = qa.pop_front();
                check("a_dout", 64'(a_dout), 64'(ea));
            end
        end
    end

    always @(negedge clk) begin
        if (!user_rst && b_dout_valid && dout_ready) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_word: got %0h expected none", b_dout);
            end else begin
                eb = qb.pop_front();
                check("b_dout", 64'(b_dout), 64'(eb));
            end
        end
    end

    initial begin
        user_rst = 1'b1; en = 1'b1; pkt_valid = 1'b0; raw = '0; par = 1'b0;
        dout_ready = 1'b0; b_mask = 1'b0;
        tick(); tick();
        user_rst = 1'b0;
        mid();
        check("rst_dout", 64'(a_dout), 64'd0);
        check("rst_valid", 64'(a_dout_valid), 64'd0);
        check("rst_empty", 64'(a_fifo_empty), 64'd1);
        check("rst_full", 64'(a_fifo_full), 64'd0);
        check("rst_pkt_cnt", 64'(a_pkt_cnt), 64'd0);
        check("rst_perr", 64'(a_perr), 64'd0);
        check("rst_ovf", 64'(a_ovf), 64'd0);

        // Single good packet: latency and one-cycle valid.
        tick();
        dout_ready = 1'b1; pkt_valid = 1'b1; raw = 34'h0_0000_0003; par = 1'b0;
        qa.push_back(38'h06_0000_0000);
        qb.push_back(38'h06_0000_0000);
        mid(); check("t1_valid_n", 64'(a_dout_valid), 64'd0);
        tick(); pkt_valid = 1'b0;
        mid(); check("t1_valid_n1", 64'(a_dout_valid), 64'd0);
        check("t1_pkt_cnt", 64'(a_pkt_cnt), 64'd1);
        check("t1_perr", 64'(a_perr), 64'd0);
        tick(); mid(); check("t1_valid_n2", 64'(a_dout_valid), 64'd1);
        tick(); mid(); check("t1_valid_n3", 64'(a_dout_valid), 64'd0);

        // Bad parity: dropped by u_a, flagged by u_b.
        tick(); pkt_valid = 1'b1; raw = 34'h0_0000_0004; par = 1'b1;
        qb.push_back(38'h07_0000_0001);
        tick(); pkt_valid = 1'b0; par = 1'b0;
        mid(); check("t2_perr_a", 64'(a_perr), 64'd1);
        check("t2_perr_b", 64'(b_perr), 64'd1);
        tick(); mid();
        check("t2_a_valid", 64'(a_dout_valid), 64'd0);
        check("t2_b_valid", 64'(b_dout_valid), 64'd1);
        check("t2_b_err_bit", 64'(b_dout[32]), 64'd1);
        check("t2_a_ovf", 64'(a_ovf), 64'd0);
        tick(); mid(); check("t2_a_empty", 64'(a_fifo_empty), 64'd1);

        // Overflow: 20 packets into a stalled 16-deep FIFO.
        tick(); dout_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pkt_valid = 1'b1; d = 32'hA000_0000 + 32'(i); raw = {d, 2'b00}; par = 1'b0;
            if (i < 16) begin
                qa.push_back({5'd3, 1'b0, d});
                qb.push_back({5'd3, 1'b0, d});
            end
            if (i == 16) begin mid(); check("t3_not_full_15", 64'(a_fifo_full), 64'd0); end
            if (i == 17) begin mid(); check("t3_full_16", 64'(a_fifo_full), 64'd1); end
        end
        tick(); pkt_valid = 1'b0;
        tick(); mid();
        check("t3_full", 64'(a_fifo_full), 64'd1);
        check("t3_ovf_a", 64'(a_ovf), 64'd4);
        check("t3_ovf_b", 64'(b_ovf), 64'd4);
        check("t3_pkt_cnt", 64'(a_pkt_cnt), 64'd22);
        tick(); dout_ready = 1'b1;
        for (int k = 0; k < 40 && !(a_fifo_empty && b_fifo_empty); k++) tick();
        mid();
        check("t3_drained_a", 64'(a_fifo_empty), 64'd1);
        check("t3_drained_b", 64'(b_fifo_empty), 64'd1);
        check("t3_qa_left", 64'(qa.size()), 64'd0);

        // Streaming at occupancy 15 with continuous input and output.
        for (int c = 0; c < 40; c++) begin
            tick();
            pkt_valid = 1'b1; d = 32'hB000_0000 + 32'(c); raw = {d, 2'b00};
            dout_ready = (c >= 16);
            qa.push_back({5'd3, 1'b0, d});
            qb.push_back({5'd3, 1'b0, d});
            if (c >= 17) begin
                mid();
                check("t4_not_full", 64'(a_fifo_full), 64'd0);
                check("t4_not_empty", 64'(a_fifo_empty), 64'd0);
            end
        end
        tick(); pkt_valid = 1'b0; dout_ready = 1'b1;
        for (int k = 0; k < 40 && !(a_fifo_empty && b_fifo_empty); k++) tick();
        mid();
        check("t4_ovf", 64'(a_ovf), 64'd4);
        check("t4_qa_left", 64'(qa.size()), 64'd0);
        check("t4_qb_left", 64'(qb.size()), 64'd0);

        // Reset with 8 words buffered and one in stage 1.
        tick(); dout_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick(); pkt_valid = 1'b1; d = 32'hC000_0000 + 32'(c); raw = {d, 2'b00};
        end
        tick(); user_rst = 1'b1; raw = {32'hC000_00FF, 2'b00};
        mid(); check("t5_pre_valid", 64'(a_dout_valid), 64'd1);
        tick(); user_rst = 1'b0; pkt_valid = 1'b0;
        mid();
        check("t5_valid", 64'(a_dout_valid), 64'd0);
        check("t5_empty", 64'(a_fifo_empty), 64'd1);
        check("t5_pkt_cnt", 64'(a_pkt_cnt), 64'd0);
        check("t5_perr", 64'(a_perr), 64'd0);
        check("t5_ovf", 64'(a_ovf), 64'd0);
        check("t5_ovf_b", 64'(b_ovf), 64'd0);
        tick(); dout_ready = 1'b1; pkt_valid = 1'b1; raw = {32'hD000_0001, 2'b00};
        qa.push_back({5'd3, 1'b0, 32'hD000_0001});
        qb.push_back({5'd3, 1'b0, 32'hD000_0001});
        mid();
        check("t5_rst_pkt_ignored", 64'(a_fifo_empty), 64'd1);
        check("t5_pkt_cnt0", 64'(a_pkt_cnt), 64'd0);
        tick(); pkt_valid = 1'b0;
        mid(); check("t5_valid_n1", 64'(a_dout_valid), 64'd0);
        tick(); mid(); check("t5_valid_n2", 64'(a_dout_valid), 64'd1);
        tick(); mid(); check("t5_valid_n3", 64'(a_dout_valid), 64'd0);

        // Capture disabled.
        tick(); en = 1'b0; pkt_valid = 1'b1; raw = {32'hE000_0000, 2'b00};
        repeat (5) tick();
        pkt_valid = 1'b0;
        tick(); tick(); mid();
        check("t6_en_pkt_cnt", 64'(a_pkt_cnt), 64'd1);
        check("t6_en_empty", 64'(a_fifo_empty), 64'd1);
        check("t6_en_empty_b", 64'(b_fifo_empty), 64'd1);

        // Parity error counter saturation.
        tick(); b_mask = 1'b1; en = 1'b1; pkt_valid = 1'b1; par = 1'b1; raw = {32'hF000_0000, 2'b00};
        repeat (65540) tick();
        pkt_valid = 1'b0; par = 1'b0;
        tick(); mid();
        check("t6_perr_sat", 64'(a_perr), 64'hFFFF);
        check("t6_pkt_cnt", 64'(a_pkt_cnt), 64'd65541);
        check("t6_ovf", 64'(a_ovf), 64'd0);
        check("t6_valid", 64'(a_dout_valid), 64'd0);
        check("t6_b_pkt_cnt", 64'(b_pkt_cnt), 64'd1);
        tick(); b_mask = 1'b0;
        tick(); mid();
        check("end_qa_left", 64'(qa.size()), 64'd0);
        check("end_qb_left", 64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_pkt_buffer.md
# tdc_pkt_buffer

Receive-side stage directly downstream of the 2-bit TDC frame decoder. Takes each 34-bit raw TDC packet and its parity result, tags it with a channel ID and an error flag, and optionally drops bad-parity words. Buffers the words in a small FIFO and presents them on a valid/ready stream to the event builder. Keeps saturating error and overflow counters for the monitoring registers.

## Interface
Parameters:
- CH_ID, 5'd0: channel number placed in dout[37:33]
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 words (min 2)
- DROP_BAD, 1: 1 = bad-parity words are not written; 0 = written with the err flag set

Ports:
- RX_FRAMECLK_I  in  1: single clock, all logic on the rising edge
- user_rst  in  1: synchronous, active-high reset
- en  in  1: capture enable; pkt_valid is ignored while en=0
- pkt_valid  in  1: one-cycle strobe, high in the cycle a new tdc_pkt_raw is presented
- tdc_pkt_raw  in  34: raw packet; the data word is bits [33:2]
- parity_chk  in  1: XOR of tdc_pkt_raw[33:2]; 1 = parity error
- dout  out  38: {CH_ID[4:0], err, tdc_pkt_raw[33:2]}
- dout_valid  out  1: head-of-FIFO word valid
- dout_ready  in  1: consumer accepts dout when dout_valid=1
- fifo_empty  out  1: FIFO empty
- fifo_full  out  1: FIFO occupancy equals 2^DEPTH_LOG2
- pkt_cnt  out  32: packets accepted at stage 1; wraps
- parity_err_cnt  out  16: parity errors; saturates at 16'hFFFF
- overflow_cnt  out  16: words dropped because the FIFO was full; saturates at 16'hFFFF

## Operation
Stage 1 (capture register):
- On pkt_valid=1 and en=1, register {CH_ID, parity_chk, tdc_pkt_raw[33:2]} and set s1_valid.
- Otherwise s1_valid=0.
- pkt_cnt increments on every capture.
- parity_err_cnt increments when a captured word has parity_chk=1.

Stage 2 (FIFO write), taken when s1_valid=1:
- If err=1 and DROP_BAD=1: no write; no overflow count.
- Else if fifo_full=1: no write; overflow_cnt increments.
- Else: write the word at wr_ptr; wr_ptr increments.

FIFO:
- Circular buffer with DEPTH_LOG2-bit pointers that wrap naturally.
- Occupancy counter is DEPTH_LOG2+1 bits; fifo_full and fifo_empty are decoded from it.
- Read (pop) happens when dout_valid=1 and dout_ready=1; rd_ptr increments.
- dout is a registered head-of-FIFO word: show-ahead; it updates on the same edge as the write into an empty FIFO, or as the pop.
- dout_valid = !fifo_empty.
- Simultaneous write and pop with 0 < occupancy < full: both happen, occupancy unchanged.
- Write while full with a simultaneous pop: the write is still dropped. Full is evaluated on the pre-edge occupancy; this is deterministic and intentional.
- Pop with dout_ready=1 while empty: no effect.
- dout holds its last value while dout_valid=0.

Reset (user_rst=1 at an edge):
- Pointers, occupancy, s1_valid and all counters go to 0.
- dout=0, dout_valid=0, fifo_empty=1, fifo_full=0.
- Reset mid-stream discards the stage-1 word and all FIFO contents.
- pkt_valid in the same cycle as user_rst is ignored.

Counters update unconditionally of dout_ready. Saturated counters hold until reset.

## Timing
- pkt_valid high in cycle N → s1_valid high in cycle N+1 → word written at end of N+1 → dout_valid high in cycle N+2 if the FIFO was empty.
- Write-to-output latency is 1 cycle; input-to-output latency is 2 cycles.
- pkt_cnt and parity_err_cnt reflect a packet from cycle N+1. overflow_cnt reflects it from cycle N+2.
- Throughput: one packet per cycle in; one word per cycle out.
- A pop at the end of cycle M presents the next word (or dout_valid=0) in cycle M+1.
- A back-to-back pkt_valid pulse every cycle must be sustained with no loss while dout_ready=1.

## Test plan
- Reset, then one packet tdc_pkt_raw=34'h0_0000_0003, parity_chk=0, CH_ID=5'd3, dout_ready=1 → dout=38'h06_0000_0000 with dout_valid exactly in cycle N+2, high for one cycle; pkt_cnt=1, parity_err_cnt=0.
- DROP_BAD=1, tdc_pkt_raw=34'h0_0000_0004, parity_chk=1 → no dout_valid; parity_err_cnt=1, overflow_cnt=0. Repeat with DROP_BAD=0 → dout err bit (bit 32)=1, data=32'h1.
- dout_ready=0, DEPTH_LOG2=4, 20 good packets back-to-back → fifo_full=1 after 16 writes; overflow_cnt=4. Drain: 16 words appear in order, then fifo_empty=1.
- FIFO at 15 words, dout_ready=1, continuous one-per-cycle input → occupancy stays at 15; zero drops; output order matches input order.
- Assert user_rst while 8 words are buffered and a packet is in stage 1 → the next cycle shows dout_valid=0, fifo_empty=1 and all counters 0; a following packet emerges normally with 2-cycle latency.
- en=0 with pkt_valid pulses → nothing written; pkt_cnt unchanged. Force 65540 parity errors → parity_err_cnt holds 16'hFFFF.
